// File: rtl/hack_rom_loader_pkg.sv
// -----------------------------------------------------------------------------
// hack_rom_loader_pkg
// Shared definitions for the Hack ROM loader: loader state encoding and the
// Hack ROM geometry (15-bit word address, 16-bit instruction).
// -----------------------------------------------------------------------------
package hack_rom_loader_pkg;

  localparam int HACK_ADDR_WIDTH = 15;
  localparam int HACK_WORD_WIDTH = 16;

  // Encoding values are fixed so that they stay stable across tools and
  // are recognisable in waveforms.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HI      = 3'd1,
    ST_LO      = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } loader_state_t;

endpackage

// File: rtl/hack_rom_loader_if.sv
// -----------------------------------------------------------------------------
// hack_rom_loader_if
// Bundles the loader's byte-stream handshake, ROM write port, CPU reset and
// status signals.
//   master : host side (drives start/in_*, observes everything else)
//   slave  : loader side (consumes start/in_*, drives ROM/status outputs)
// Signals:
//   start       load request pulse
//   in_data     stream byte, in_valid/in_ready handshake, in_last marks end
//   rom_we/rom_addr/rom_din   ROM write port
//   cpu_reset   active-high reset to the Computer
//   busy/done/error/word_count   load status
// -----------------------------------------------------------------------------
interface hack_rom_loader_if
  import hack_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = HACK_ADDR_WIDTH,
  parameter int WORD_WIDTH = HACK_WORD_WIDTH
);

  logic                  start;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic                  rom_we;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [WORD_WIDTH-1:0] rom_din;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH:0]   word_count;

  modport master (
    output start, in_data, in_valid, in_last,
    input  in_ready, rom_we, rom_addr, rom_din, cpu_reset,
           busy, done, error, word_count
  );

  modport slave (
    input  start, in_data, in_valid, in_last,
    output in_ready, rom_we, rom_addr, rom_din, cpu_reset,
           busy, done, error, word_count
  );

endinterface

// File: rtl/hack_rom_loader_release_timer.sv
// -----------------------------------------------------------------------------
// hack_rom_loader_release_timer
// Loadable down-counter that times how long the CPU is kept in reset after
// the final ROM write.
// Ports:
//   clock      system clock
//   reset      asynchronous active-low reset
//   i_load     reload the counter (one cycle before counting starts)
//   i_enable   count down while high
//   o_expired  high once RELEASE_CYCLES enabled cycles have elapsed
// -----------------------------------------------------------------------------
module hack_rom_loader_release_timer #(
  parameter int RELEASE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  // Loading N-1 means the N-th enabled cycle sees zero and reports expiry.
  localparam logic [CW-1:0] LP_LOAD = CW'(RELEASE_CYCLES - 1);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LP_LOAD;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - LP_ONE;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/hack_rom_loader.sv
// -----------------------------------------------------------------------------
// hack_rom_loader
// Synthesizable writer for the Hack instruction ROM. Assembles big-endian
// 16-bit instructions from a byte stream, writes them to consecutive ROM
// addresses from 0, holds the Computer in reset while loading and releases
// it RELEASE_CYCLES clocks after the last write.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    hack_rom_loader_if.slave (stream in, ROM write port, status out)
// -----------------------------------------------------------------------------
module hack_rom_loader
  import hack_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = HACK_ADDR_WIDTH,
  parameter int WORD_WIDTH     = HACK_WORD_WIDTH,
  parameter int MAX_WORDS      = 32768,
  parameter int RELEASE_CYCLES = 4
) (
  input logic              clock,
  input logic              reset,
  hack_rom_loader_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]   LP_MAX_COUNT = (ADDR_WIDTH + 1)'(MAX_WORDS);
  localparam logic [ADDR_WIDTH:0]   LP_CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LP_ADDR_ONE  = ADDR_WIDTH'(1);

  loader_state_t         r_state;
  logic [7:0]            r_hi;
  logic                  r_last;
  logic                  r_in_ready;
  logic                  r_rom_we;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [WORD_WIDTH-1:0] r_rom_din;
  logic                  r_cpu_reset;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [ADDR_WIDTH:0]   r_word_count;

  logic                  w_xfer;
  logic [ADDR_WIDTH:0]   w_count_next;
  logic                  w_timer_load;
  logic                  w_timer_run;
  logic                  w_timer_expired;

  assign w_xfer       = bus.in_valid & r_in_ready;
  assign w_count_next = r_word_count + LP_CNT_ONE;
  // Timer is armed during the final write so RELEASE counts from its first cycle.
  assign w_timer_load = (r_state == ST_WRITE) && r_last;
  assign w_timer_run  = (r_state == ST_RELEASE);

  hack_rom_loader_release_timer #(
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) u_release_timer (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_timer_load),
    .i_enable (w_timer_run),
    .o_expired(w_timer_expired)
  );

  // Loader FSM. All outputs are registered and updated alongside the state,
  // so in_ready depends on state only and never on in_valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_hi         <= '0;
      r_last       <= 1'b0;
      r_in_ready   <= 1'b0;
      r_rom_we     <= 1'b0;
      r_rom_addr   <= '0;
      r_rom_din    <= '0;
      r_cpu_reset  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_rom_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start) begin
            r_state      <= ST_HI;
            r_in_ready   <= 1'b1;
            r_rom_addr   <= '0;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        ST_HI: begin
          if (w_xfer) begin
            r_hi <= bus.in_data;
            // A program that ends on a high byte has an odd byte count.
            if (bus.in_last) begin
              r_state    <= ST_ERR;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_state <= ST_LO;
            end
          end
        end
        ST_LO: begin
          if (w_xfer) begin
            r_rom_din  <= {r_hi, bus.in_data};
            r_last     <= bus.in_last;
            r_rom_we   <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // rom_addr is held through this cycle so it matches rom_we/rom_din.
          r_rom_addr   <= r_rom_addr + LP_ADDR_ONE;
          r_word_count <= w_count_next;
          if (r_last) begin
            r_state <= ST_RELEASE;
          end else if (w_count_next == LP_MAX_COUNT) begin
            r_state <= ST_ERR;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= ST_HI;
            r_in_ready <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (w_timer_expired) begin
            r_state     <= ST_DONE;
            r_cpu_reset <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.rom_we     = r_rom_we;
  assign bus.rom_addr   = r_rom_addr;
  assign bus.rom_din    = r_rom_din;
  assign bus.cpu_reset  = r_cpu_reset;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_hack_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_hack_rom_loader
// Directed bench for hack_rom_loader. Expected ROM writes are queued as words
// are sent; a negedge monitor pops and compares each rom_we cycle. The DUT is
// built with MAX_WORDS=4 so the overflow case is reachable in a short run;
// the other scenarios stay below that capacity.
// -----------------------------------------------------------------------------
module tb_hack_rom_loader;

  localparam int RELEASE_CYCLES = 4;

  logic clock;
  logic reset;

  hack_rom_loader_if #(.ADDR_WIDTH(15), .WORD_WIDTH(16)) bus ();

  hack_rom_loader #(
    .ADDR_WIDTH    (15),
    .WORD_WIDTH    (16),
    .MAX_WORDS     (4),
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int nChecks = 0;
  int nFail = 0;
  int cyc = 0;
  int lastWeCycle = 0;
  logic prevWe = 1'b0;
  logic lastAccepted;
  logic [30:0] expQ[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Free-running cycle counter used to measure release latency.
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every ROM write must match the oldest queued word,
  // and rom_we must never stay high for two cycles.
  initial forever begin
    logic [30:0] exp;
    @(negedge clock);
    if (prevWe) checkOutput("wePulseWidth", 32'(bus.rom_we), 32'h0);
    if (bus.rom_we) begin
      lastWeCycle = cyc;
      if (expQ.size() == 0) begin
        checkOutput("writeExpected", 32'(expQ.size()), 32'h1);
      end else begin
        exp = expQ.pop_front();
        checkOutput("romAddr", 32'(bus.rom_addr), 32'(exp[30:16]));
        checkOutput("romDin", 32'(bus.rom_din), 32'(exp[15:0]));
      end
    end
    prevWe = bus.rom_we;
  end

  // Offers one byte; optional random idle cycles before valid. Called and
  // returns at posedge+1.
  task automatic applyStimulus(input logic [7:0] b, input logic last,
                               input logic rnd);
    logic acc;
    if (rnd) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock);
        #1;
      end
    end
    bus.in_data  = b;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    lastAccepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      acc = bus.in_ready;
      @(posedge clock);
      #1;
      if (acc) begin
        lastAccepted = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!lastAccepted) checkOutput("byteAccepted", 32'(lastAccepted), 32'h1);
  endtask

  task automatic sendWord(input logic [14:0] addr, input logic [15:0] w,
                          input logic last, input logic rnd);
    expQ.push_back({addr, w});
    applyStimulus(w[15:8], 1'b0, rnd);
    applyStimulus(w[7:0], last, rnd);
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  // Waits for cpu_reset to drop and checks latency from the last write edge.
  task automatic waitRelease(input string tag, input int words);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!bus.cpu_reset) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_released"}, 32'(seen), 32'h1);
    // rom_we is seen in the cycle before the write edge, hence the +1.
    checkOutput({tag, "_releaseDelay"}, 32'(cyc - lastWeCycle),
                32'(RELEASE_CYCLES + 1));
    checkOutput({tag, "_done"}, 32'(bus.done), 32'h1);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'h0);
    checkOutput({tag, "_wordCount"}, 32'(bus.word_count), 32'(words));
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    // Reset held for three clocks, then idle without start.
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    checkOutput("rst_cpuReset", 32'(bus.cpu_reset), 32'h1);
    checkOutput("rst_inReady", 32'(bus.in_ready), 32'h0);
    checkOutput("rst_done", 32'(bus.done), 32'h0);
    checkOutput("rst_error", 32'(bus.error), 32'h0);
    checkOutput("rst_romAddr", 32'(bus.rom_addr), 32'h0);
    checkOutput("rst_wordCount", 32'(bus.word_count), 32'h0);

    // Two-word program with continuous valid.
    pulseStart();
    checkOutput("t2_busy", 32'(bus.busy), 32'h1);
    checkOutput("t2_inReady", 32'(bus.in_ready), 32'h1);
    sendWord(15'd0, 16'hEC10, 1'b0, 1'b0);
    sendWord(15'd1, 16'hE308, 1'b1, 1'b0);
    waitRelease("t2", 2);

    // Same program with random valid gaps and an ignored start mid-load.
    pulseStart();
    checkOutput("t3_doneCleared", 32'(bus.done), 32'h0);
    checkOutput("t3_cpuReset", 32'(bus.cpu_reset), 32'h1);
    expQ.push_back({15'd0, 16'hEC10});
    expQ.push_back({15'd1, 16'hE308});
    applyStimulus(8'hEC, 1'b0, 1'b1);
    pulseStart();
    applyStimulus(8'h10, 1'b0, 1'b1);
    applyStimulus(8'hE3, 1'b0, 1'b1);
    applyStimulus(8'h08, 1'b1, 1'b1);
    waitRelease("t3", 2);

    // Odd byte count: one word written, then error.
    pulseStart();
    sendWord(15'd0, 16'hABCD, 1'b0, 1'b0);
    applyStimulus(8'h12, 1'b1, 1'b0);
    checkOutput("t4_error", 32'(bus.error), 32'h1);
    checkOutput("t4_cpuReset", 32'(bus.cpu_reset), 32'h1);
    checkOutput("t4_done", 32'(bus.done), 32'h0);
    checkOutput("t4_busy", 32'(bus.busy), 32'h0);
    checkOutput("t4_wordCount", 32'(bus.word_count), 32'h1);
    pulseStart();
    checkOutput("t4_errorCleared", 32'(bus.error), 32'h0);
    sendWord(15'd0, 16'hEC10, 1'b0, 1'b0);
    sendWord(15'd1, 16'hE308, 1'b1, 1'b0);
    waitRelease("t4", 2);

    // Overflow at MAX_WORDS=4: fifth word must not be consumed.
    pulseStart();
    sendWord(15'd0, 16'h1122, 1'b0, 1'b0);
    sendWord(15'd1, 16'h3344, 1'b0, 1'b0);
    sendWord(15'd2, 16'h5566, 1'b0, 1'b0);
    sendWord(15'd3, 16'h7788, 1'b0, 1'b0);
    begin
      logic consumed;
      consumed = 1'b0;
      bus.in_data  = 8'h99;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        if (bus.in_ready) consumed = 1'b1;
        @(posedge clock);
        #1;
      end
      bus.in_valid = 1'b0;
      checkOutput("t5_fifthConsumed", 32'(consumed), 32'h0);
    end
    checkOutput("t5_error", 32'(bus.error), 32'h1);
    checkOutput("t5_inReady", 32'(bus.in_ready), 32'h0);
    checkOutput("t5_wordCount", 32'(bus.word_count), 32'h4);
    checkOutput("t5_cpuReset", 32'(bus.cpu_reset), 32'h1);

    // Async reset during LO of word 3, then a clean reload.
    pulseStart();
    sendWord(15'd0, 16'h0102, 1'b0, 1'b0);
    sendWord(15'd1, 16'h0304, 1'b0, 1'b0);
    applyStimulus(8'h05, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_flags", 32'({bus.cpu_reset, bus.in_ready, bus.rom_we,
                                 bus.busy, bus.done, bus.error}), 32'h20);
    checkOutput("t6_romAddr", 32'(bus.rom_addr), 32'h0);
    checkOutput("t6_wordCount", 32'(bus.word_count), 32'h0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    pulseStart();
    sendWord(15'd0, 16'hEC10, 1'b0, 1'b0);
    sendWord(15'd1, 16'hE308, 1'b1, 1'b0);
    waitRelease("t6", 2);

    repeat (3) begin
      @(posedge clock);
      #1;
    end
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
